// File: rtl/float2fix_pipe_pkg.sv
// Shared constants and stage records for the float-to-fixed pipeline.
package float2fix_pipe_pkg;

    // IEEE-754 single-precision fields
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Widest supported output; the magnitude field is one bit wider so a
    // magnitude of exactly 2^(OUT_W-1) (the most negative value) is representable.
    localparam int MAX_OUT_W = 64;
    localparam int MAG_W     = MAX_OUT_W + 1;

    // src_mode bit indices
    localparam int MODE_RND = 0;  // 0 truncate toward zero, 1 round-nearest-even
    localparam int MODE_SAT = 1;  // 0 wrap, 1 saturate

    // dst_flags bit indices
    localparam int FLG_INX = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_NAN = 2;

    typedef enum logic [1:0] {
        CLS_ZERO,   // zero or denormal
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } f2f_cls_e;

    // S1: unpacked and classified input word
    typedef struct packed {
        logic             valid;
        logic             sign;
        f2f_cls_e         cls;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   mant;   // hidden bit included
        logic [1:0]       mode;
    } f2f_unpk_t;

    // S2: aligned magnitude with guard/sticky; big flags bits lost above MAG_W
    typedef struct packed {
        logic             valid;
        logic             sign;
        f2f_cls_e         cls;
        logic [MAG_W-1:0] mag;
        logic             big;
        logic             guard;
        logic             sticky;
        logic [1:0]       mode;
    } f2f_stage_t;

endpackage

// File: rtl/f2f_round_sat.sv
// Final stage: round the magnitude, negate, then saturate or wrap and raise flags.
module f2f_round_sat
    import float2fix_pipe_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  f2f_stage_t       rec_i,
    output logic             vld_o,
    output logic [OUT_W-1:0] dst_o,
    output logic [2:0]       flags_o
);

    localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    logic             inc;
    logic             ovf;
    logic [MAG_W:0]   rnd;
    logic [MAG_W:0]   half;
    logic [OUT_W-1:0] low;

    // Magnitude is rounded before negation so truncation is toward zero for both signs
    always_comb begin
        half          = '0;
        half[OUT_W-1] = 1'b1;
        inc     = rec_i.mode[MODE_RND] & rec_i.guard & (rec_i.sticky | rec_i.mag[0]);
        rnd     = {1'b0, rec_i.mag} + {{MAG_W{1'b0}}, inc};
        // Negative side reaches one further: -2^(OUT_W-1) is in range
        ovf     = rec_i.big | (rec_i.sign ? (rnd > half) : (rnd >= half));
        low     = rnd[OUT_W-1:0];
        vld_o   = rec_i.valid;
        dst_o   = '0;
        flags_o = '0;
        case (rec_i.cls)
            CLS_NAN:  flags_o[FLG_NAN] = 1'b1;
            CLS_INF: begin
                dst_o            = rec_i.sign ? MINV : MAXV;
                flags_o[FLG_OVF] = 1'b1;
            end
            CLS_ZERO: flags_o[FLG_INX] = rec_i.sticky;
            default: begin
                if (ovf && rec_i.mode[MODE_SAT])
                    dst_o = rec_i.sign ? MINV : MAXV;
                else
                    dst_o = rec_i.sign ? (~low + 1'b1) : low;
                flags_o[FLG_OVF] = ovf;
                flags_o[FLG_INX] = ~ovf & (rec_i.guard | rec_i.sticky);
            end
        endcase
    end

endmodule

// File: rtl/float2fix_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with global stall.
module float2fix_pipe
    import float2fix_pipe_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [31:0]      src,
    input  logic [1:0]       src_mode,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [OUT_W-1:0] dst,
    output logic [2:0]       dst_flags,
    output logic [15:0]      ovf_cnt
);

    localparam int RW = 2 * MAN_W + 3;  // right-shift window: mantissa + guard + sticky room

    f2f_unpk_t        s1_d, s1_q;
    f2f_stage_t       s2_d, s2_q;
    logic             s3_vld_d, dst_valid_q;
    logic [OUT_W-1:0] dst_d, dst_q;
    logic [2:0]       flags_d, flags_q;
    logic [15:0]      ovf_cnt_q;
    logic             en;

    logic signed [9:0]  sh;
    logic [8:0]         lsh, rsh;
    logic [MAG_W+MAN_W:0] lwide;
    logic [RW-1:0]      rwide;

    assign en        = ~dst_valid_q | dst_ready;
    assign src_ready = rst | en;

    // S1: split fields and classify
    always_comb begin
        s1_d       = '0;
        s1_d.valid = src_valid & src_ready;
        s1_d.sign  = src[31];
        s1_d.exp   = src[30:23];
        s1_d.mant  = {|src[30:23], src[22:0]};
        s1_d.mode  = src_mode;
        if (src[30:23] == '0)
            s1_d.cls = CLS_ZERO;
        else if (src[30:23] == '1)
            s1_d.cls = (src[22:0] != '0) ? CLS_NAN : CLS_INF;
        else
            s1_d.cls = CLS_NORM;
    end

    // S2: align the mantissa to the output binary point, keeping guard and sticky
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.cls   = s1_q.cls;
        s2_d.mode  = s1_q.mode;
        sh    = $signed({2'b00, s1_q.exp}) - $signed(10'(BIAS + MAN_W)) + $signed(10'(FRAC_W));
        lsh   = sh[8:0];
        rsh   = ~sh[8:0] + 9'd1;
        lwide = {{MAG_W{1'b0}}, s1_q.mant} << lsh;
        rwide = {s1_q.mant, {(MAN_W+2){1'b0}}} >> rsh;
        if (s1_q.cls == CLS_ZERO) begin
            s2_d.sticky = |s1_q.mant;
        end else if (s1_q.cls == CLS_NORM) begin
            if (!sh[9]) begin
                s2_d.mag = lwide[MAG_W-1:0];
                s2_d.big = (|lwide[MAG_W+MAN_W:MAG_W]) | (32'(lsh) >= MAG_W);
            end else if (32'(rsh) > RW - 1) begin
                // every mantissa bit lies below the guard position
                s2_d.sticky = 1'b1;
            end else begin
                s2_d.mag    = {{(MAG_W-MAN_W-1){1'b0}}, rwide[RW-1:MAN_W+2]};
                s2_d.guard  = rwide[MAN_W+1];
                s2_d.sticky = |rwide[MAN_W:0];
            end
        end
    end

    // S3 combinational round/saturate
    f2f_round_sat #(.OUT_W(OUT_W)) u_rs (
        .rec_i   (s2_q),
        .vld_o   (s3_vld_d),
        .dst_o   (dst_d),
        .flags_o (flags_d)
    );

    // Pipeline registers: all stages advance together or hold together
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid  <= 1'b0;
            s2_q.valid  <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_q       <= '0;
            flags_q     <= '0;
        end else if (en) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            dst_valid_q <= s3_vld_d;
            if (s3_vld_d) begin
                dst_q   <= dst_d;
                flags_q <= flags_d;
            end
        end
    end

    // Saturating count of delivered overflow words
    always_ff @(posedge clk) begin
        if (rst)
            ovf_cnt_q <= '0;
        else if (dst_valid_q && dst_ready && flags_q[FLG_OVF] && ovf_cnt_q != 16'hFFFF)
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign dst_valid = dst_valid_q;
    assign dst       = dst_q;
    assign dst_flags = flags_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_float2fix_pipe.sv
// Directed bench for float2fix_pipe at OUT_W=32, FRAC_W=16.
module tb_float2fix_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src;
    logic [1:0]  src_mode;
    logic        dst_valid;
    logic        dst_ready;
    logic [31:0] dst;
    logic [2:0]  dst_flags;
    logic [15:0] ovf_cnt;

    int errs   = 0;
    int checks = 0;

    float2fix_pipe #(.OUT_W(32), .FRAC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src       (src),
        .src_mode  (src_mode),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst       (dst),
        .dst_flags (dst_flags),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // Send one word, wait (bounded) for it, check latency, data and flags.
    task automatic run1(input string tag, input logic [31:0] w, input logic [1:0] m,
                        input logic [31:0] ed, input logic [2:0] ef);
        int n;
        @(negedge clk);
        src = w; src_mode = m; src_valid = 1'b1;
        #1 chk({tag, "_acc"}, 64'(src_ready), 64'd1);
        @(negedge clk);
        src_valid = 1'b0; src = 32'h3F800000; src_mode = ~m;  // later mode must not leak in
        n = 1;
        while (!dst_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd3);
        chk({tag, "_dst"}, 64'(dst), 64'(ed));
        chk({tag, "_flg"}, 64'(dst_flags), 64'(ef));
    endtask

    logic [31:0] sw [4];
    logic [31:0] got [$];
    int          widx, stalls, nv;
    logic [31:0] held;
    bit          was_stall;

    initial begin
        rst = 1'b1; src_valid = 1'b0; src = '0; src_mode = '0; dst_ready = 1'b0;
        @(negedge clk);
        #1 chk("rst_ready", 64'(src_ready), 64'd1);
        @(negedge clk);
        chk("rst_vld", 64'(dst_valid), 64'd0);
        chk("rst_cnt", 64'(ovf_cnt), 64'd0);
        chk("rst_dst", 64'(dst), 64'd0);
        rst = 1'b0; dst_ready = 1'b1;

        // basic values, rounding and ties
        run1("p1_5",    32'h3FC00000, 2'd0, 32'h00018000, 3'b000);
        run1("q625_t",  32'h37200000, 2'd0, 32'h00000000, 3'b001);
        run1("q625_r",  32'h37200000, 2'd1, 32'h00000001, 3'b001);
        run1("h05_r",   32'h37000000, 2'd1, 32'h00000000, 3'b001);
        run1("h15_r",   32'h37C00000, 2'd1, 32'h00000002, 3'b001);
        run1("n15l_r",  32'hB7C00000, 2'd1, 32'hFFFFFFFE, 3'b001);
        run1("n15l_t",  32'hB7C00000, 2'd0, 32'hFFFFFFFF, 3'b001);
        run1("denorm",  32'h00000001, 2'd1, 32'h00000000, 3'b001);
        run1("zero",    32'h80000000, 2'd1, 32'h00000000, 3'b000);
        run1("big_sat", 32'h471C4000, 2'd3, 32'h7FFFFFFF, 3'b010);
        run1("big_wrp", 32'h471C4000, 2'd1, 32'h9C400000, 3'b010);
        @(negedge clk);
        chk("cnt2", 64'(ovf_cnt), 64'd2);
        run1("nan",     32'h7FC00000, 2'd3, 32'h00000000, 3'b100);
        run1("ninf",    32'hFF800000, 2'd0, 32'h80000000, 3'b010);
        run1("m1_5",    32'hBFC00000, 2'd0, 32'hFFFE8000, 3'b000);
        @(negedge clk);
        chk("cnt3", 64'(ovf_cnt), 64'd3);

        // stream 4 words, dst_ready low for cycles 2..6
        sw[0] = 32'h3F800000; sw[1] = 32'h40000000; sw[2] = 32'h40400000; sw[3] = 32'h40800000;
        widx = 0; stalls = 0; was_stall = 0; held = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dst_ready = !(c >= 2 && c < 7);
            src_valid = (widx < 4);
            src       = (widx < 4) ? sw[widx] : 32'h0;
            src_mode  = 2'd1;
            #1;
            if (dst_valid && !dst_ready) begin
                stalls++;
                chk("stall_rdy", 64'(src_ready), 64'd0);
                if (was_stall) chk("stall_hold", 64'(dst), 64'(held));
                held = dst; was_stall = 1;
            end else begin
                was_stall = 0;
            end
            if (dst_valid && dst_ready) got.push_back(dst);
            if (src_valid && src_ready) widx++;
        end
        src_valid = 1'b0; dst_ready = 1'b1;
        chk("stall_cyc", 64'(stalls), 64'd4);
        chk("strm_cnt", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("strm_%0d", i), 64'(got[i]), 64'(32'h00010000 * (i + 1)));

        // reset with two overflow words in flight
        chk("pre_rst_cnt", 64'(ovf_cnt), 64'd3);
        @(negedge clk); src = 32'h7F800000; src_mode = 2'd0; src_valid = 1'b1;
        @(negedge clk); src = 32'hFF800000;
        @(negedge clk); src_valid = 1'b0; rst = 1'b1;
        #1 chk("midrst_rdy", 64'(src_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        chk("midrst_vld", 64'(dst_valid), 64'd0);
        chk("midrst_cnt", 64'(ovf_cnt), 64'd0);
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (dst_valid) nv++;
        end
        chk("midrst_stale", 64'(nv), 64'd0);
        chk("midrst_dst", 64'(dst), 64'd0);

        // overflow counter: exact count, then saturation
        @(negedge clk); src = 32'h7F800000; src_mode = 2'd0; src_valid = 1'b1;
        repeat (1000) @(negedge clk);
        src_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("cnt1000", 64'(ovf_cnt), 64'd1000);
        src_valid = 1'b1;
        repeat (65540) @(negedge clk);
        src_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("cnt_sat", 64'(ovf_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
